// File: rtl/ring_reduce_countdown_pkg.sv
// Shared definitions for the ring_reduce_countdown block: FSM state
// encoding, reduction-operator codes and a width helper.
package ring_reduce_countdown_pkg;

    // Top-level FSM states (also driven out on state_o)
    localparam logic [1:0] S_FILL   = 2'd0;
    localparam logic [1:0] S_REDUCE = 2'd1;
    localparam logic [1:0] S_COUNT  = 2'd2;

    // Reduction operators selected by the mode input
    localparam logic [1:0] MODE_AND = 2'd0;
    localparam logic [1:0] MODE_OR  = 2'd1;
    localparam logic [1:0] MODE_XOR = 2'd2;
    localparam logic [1:0] MODE_MAX = 2'd3;

    // Bits needed to index 'value' distinct codes; never less than 1 so
    // that degenerate parameters still give a legal vector width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/ring_reduce_countdown_key_conditioner.sv
// key_conditioner: turns a raw key level into a single-cycle pulse.
// An optional debouncer (DEB_CYCLES > 0) only accepts a new level after it
// has differed from the accepted level for DEB_CYCLES consecutive clocks.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   key        : raw key level
//   pulse      : one-cycle pulse per accepted rising edge
module key_conditioner
    import ring_reduce_countdown_pkg::*;
#(
    parameter int DEB_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic pulse
);

    logic level;
    logic level_q;

    generate
        if (DEB_CYCLES == 0) begin : g_no_debounce
            assign level = key;
        end else begin : g_debounce
            localparam int CNT_W = clog2(DEB_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic             stable_q;

            // Any return to the accepted level restarts the stability count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else if (key != stable_q) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q    <= '0;
                        stable_q <= key;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end

            assign level = stable_q;
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/ring_reduce_countdown.sv
// ring_reduce_countdown: DEPTH-slot ring filled from switches via key
// pulses, reduced to one word by a selectable operator, then counted down
// to zero with one step every NUM+1 clocks before returning to fill.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   data_in    : word written on a load pulse
//   inc        : raw advance/confirm key
//   ld         : raw load/abort key (optionally debounced)
//   mode       : reduction operator (AND, OR, XOR, unsigned MAX)
//   data_out   : buf[wr_ptr] in FILL, accumulator otherwise
//   state_o    : current FSM state
//   full       : every slot holds a loaded value
//   done       : one-cycle pulse when the countdown finishes
module ring_reduce_countdown
    import ring_reduce_countdown_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 3,
    parameter int NUM        = 8,
    parameter int DEB_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             inc,
    input  logic             ld,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] data_out,
    output logic [1:0]       state_o,
    output logic             full,
    output logic             done
);

    localparam int PTR_W   = clog2(DEPTH);
    localparam int TIMER_W = clog2(NUM + 1);
    localparam logic [PTR_W-1:0]   LAST_SLOT = PTR_W'(DEPTH - 1);
    localparam logic [TIMER_W-1:0] TICK_LAST = TIMER_W'(NUM);
    localparam logic [WIDTH-1:0]   ACC_ONE   = WIDTH'(1);

    logic [WIDTH-1:0]   buf_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [WIDTH-1:0]   acc_q;
    logic [TIMER_W-1:0] timer_q;
    logic [1:0]         state_q;
    logic               done_q;

    logic               inc_p;
    logic               ld_p;
    logic [PTR_W-1:0]   next_ptr;
    logic [WIDTH-1:0]   reduced;
    logic               clear_ring;

    key_conditioner #(.DEB_CYCLES(0)) u_inc_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (inc),
        .pulse (inc_p)
    );

    key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_ld_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (ld),
        .pulse (ld_p)
    );

    assign next_ptr = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
    assign full     = &valid_q;
    assign done     = done_q;
    assign state_o  = state_q;
    assign data_out = (state_q == S_FILL) ? buf_q[wr_ptr_q] : acc_q;

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        reduced = buf_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            case (mode)
                MODE_AND: reduced = reduced & buf_q[i];
                MODE_OR:  reduced = reduced | buf_q[i];
                MODE_XOR: reduced = reduced ^ buf_q[i];
                default:  if (buf_q[i] > reduced) reduced = buf_q[i];
            endcase
        end
    end

    // Every exit back to FILL (zero result, countdown end, abort) empties
    // the ring so the next fill starts from slot 0.
    always_comb begin
        clear_ring = 1'b0;
        case (state_q)
            S_REDUCE: clear_ring = inc_p && (acc_q == '0);
            S_COUNT:  clear_ring = ld_p || ((timer_q == TICK_LAST) && (acc_q == ACC_ONE));
            default:  clear_ring = 1'b0;
        endcase
    end

    // NOTE: the ring storage is reset explicitly because a reset must make
    // the displayed slot value 0, not whatever was loaded before.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            valid_q  <= '0;
            wr_ptr_q <= '0;
        end else if (clear_ring) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            valid_q  <= '0;
            wr_ptr_q <= '0;
        end else if (state_q == S_FILL && !full) begin
            // A load wins over a coincident advance; both move one slot.
            if (ld_p) begin
                buf_q[wr_ptr_q]   <= data_in;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= next_ptr;
            end else if (inc_p) begin
                wr_ptr_q <= next_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            timer_q <= '0;
            state_q <= S_FILL;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_FILL: begin
                    if (full) state_q <= S_REDUCE;
                end
                S_REDUCE: begin
                    if (inc_p) begin
                        if (acc_q == '0) begin
                            state_q <= S_FILL;
                        end else begin
                            timer_q <= '0;
                            state_q <= S_COUNT;
                        end
                    end else begin
                        acc_q <= reduced;
                    end
                end
                S_COUNT: begin
                    if (ld_p) begin
                        state_q <= S_FILL;
                    end else if (timer_q == TICK_LAST) begin
                        timer_q <= '0;
                        acc_q   <= acc_q - 1'b1;
                        // Leaving at 1 means the decrement never wraps.
                        if (acc_q == ACC_ONE) begin
                            done_q  <= 1'b1;
                            state_q <= S_FILL;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

endmodule
